// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card initialisation sequencer with a two-way byte arbiter (formatter vs sequencer).
// Define SD_INIT_OCR_EN to add the CMD58/OCR read that sets card_hc.
module sd_init_sequencer #(
  parameter int unsigned DUMMY_BYTES    = 10,
  parameter int unsigned RESP_POLL      = 8,
  parameter int unsigned ACMD41_RETRIES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic        card_hc,
  output logic        cs_n,
  output logic        com_start,
  output logic [7:0]  com_cmd,
  output logic [23:0] com_arg,
  input  logic        com_rdy,
  input  logic        cmdr_start,
  input  logic [7:0]  cmdr_data,
  output logic        cmdr_rdy,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_rdy,
  input  logic [7:0]  spi_rx
);

  localparam int unsigned CNT_MAX = (DUMMY_BYTES > RESP_POLL) ? DUMMY_BYTES : RESP_POLL;
  localparam int unsigned CNT_W   = $clog2((CNT_MAX > 4) ? CNT_MAX : 4);
  localparam int unsigned RTRY_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_ISSUE, S_WAIT_CMD, S_POLL, S_EVAL, S_TAIL, S_GAP, S_DONE, S_FAIL
  } state_t;

  typedef enum logic [2:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58, C_END} cmd_t;

  state_t             state, state_d;
  cmd_t               cmd, cmd_d, nxt, nxt_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [RTRY_W-1:0]  retry, retry_d, retry_inc;
  logic [7:0]         r1, r1_d, tail_b, tail_d;
  logic               pend, pend_d, seq_start, seq_start_d;
  logic               done_d, err_d, hc_d, cs_n_d;
  logic [2:0]         code_d, fail_code;
  logic               fail_go, byte_done, byte_state, sel_cmdr;

  // {com_cmd, com_arg} for each command
  function automatic logic [31:0] cmd_enc(input cmd_t c);
    unique case (c)
      C_CMD8:   cmd_enc = 32'h08_0001AA;
      C_CMD55:  cmd_enc = 32'h37_000000;
      C_ACMD41: cmd_enc = 32'h69_000000;
      C_CMD58:  cmd_enc = 32'h3A_000000;
      default:  cmd_enc = 32'h00_000000;
    endcase
  endfunction

  // Byte arbiter: the formatter owns the transceiver from com_start until com_rdy
  assign sel_cmdr  = (state == S_ISSUE) || (state == S_WAIT_CMD);
  assign spi_start = sel_cmdr ? cmdr_start : seq_start;
  assign spi_data  = sel_cmdr ? cmdr_data  : 8'hFF;
  assign cmdr_rdy  = sel_cmdr & spi_rdy;

  assign retry_inc = (retry == {RTRY_W{1'b1}}) ? retry : retry + RTRY_W'(1);

  always_comb begin
    state_d     = state;
    cmd_d       = cmd;
    nxt_d       = nxt;
    cnt_d       = cnt;
    retry_d     = retry;
    r1_d        = r1;
    tail_d      = tail_b;
    pend_d      = pend;
    seq_start_d = 1'b0;
    done_d      = init_done;
    err_d       = init_err;
    code_d      = err_code;
    hc_d        = card_hc;
    fail_go     = 1'b0;
    fail_code   = 3'd0;
    cs_n_d      = 1'b1;
    byte_done   = pend & spi_rdy;
    byte_state  = (state == S_PWRUP) || (state == S_POLL) || (state == S_TAIL) || (state == S_GAP);

    // Sequencer-owned bytes: one start pulse, then wait for spi_rdy
    if (byte_state && !pend) begin
      seq_start_d = 1'b1;
      pend_d      = 1'b1;
    end
    if (byte_done) pend_d = 1'b0;

    unique case (state)
      S_IDLE: if (init_start) begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = 3'd0;
        hc_d    = 1'b0;
        cnt_d   = '0;
        retry_d = '0;
        cmd_d   = C_CMD0;
        state_d = S_PWRUP;
      end
      S_PWRUP: if (byte_done) begin
        if (cnt == CNT_W'(DUMMY_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else cnt_d = cnt + CNT_W'(1);
      end
      S_ISSUE: state_d = S_WAIT_CMD;
      S_WAIT_CMD: if (com_rdy) begin
        cnt_d   = '0;
        state_d = S_POLL;
      end
      S_POLL: if (byte_done) begin
        if (!spi_rx[7]) begin
          r1_d    = spi_rx;
          state_d = S_EVAL;
        end else if (cnt == CNT_W'(RESP_POLL - 1)) begin
          fail_go   = 1'b1;
          fail_code = 3'd4;
        end else cnt_d = cnt + CNT_W'(1);
      end
      S_EVAL: begin
        cnt_d = '0;
        unique case (cmd)
          C_CMD0: if (r1 == 8'h01) begin nxt_d = C_CMD8; state_d = S_GAP; end
                  else begin fail_go = 1'b1; fail_code = 3'd1; end
          C_CMD8: if (r1[2]) begin fail_go = 1'b1; fail_code = 3'd5; end
                  else if (r1 == 8'h01) state_d = S_TAIL;
                  else begin fail_go = 1'b1; fail_code = 3'd1; end
          C_CMD55: begin nxt_d = C_ACMD41; state_d = S_GAP; end
          C_ACMD41: if (r1 == 8'h00) begin
`ifdef SD_INIT_OCR_EN
            nxt_d = C_CMD58;
`else
            nxt_d = C_END;
`endif
            state_d = S_GAP;
          end else if (r1 == 8'h01) begin
            retry_d = retry_inc;
            if (retry_inc >= RTRY_W'(ACMD41_RETRIES)) begin fail_go = 1'b1; fail_code = 3'd3; end
            else begin nxt_d = C_CMD55; state_d = S_GAP; end
          end else begin fail_go = 1'b1; fail_code = 3'd1; end
          C_CMD58: if (r1 == 8'h00) state_d = S_TAIL;
                   else begin fail_go = 1'b1; fail_code = 3'd1; end
          default: state_d = S_IDLE;
        endcase
      end
      S_TAIL: if (byte_done) begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(2)) tail_d = spi_rx;
`ifdef SD_INIT_OCR_EN
        if (cnt == '0 && cmd == C_CMD58) hc_d = spi_rx[6];
`endif
        if (cnt == CNT_W'(3)) begin
          cnt_d = '0;
          if (cmd == C_CMD8) begin
            if (tail_b == 8'h01 && spi_rx == 8'hAA) begin nxt_d = C_CMD55; state_d = S_GAP; end
            else begin fail_go = 1'b1; fail_code = 3'd2; end
          end else begin
            nxt_d   = C_END;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: if (byte_done) begin
        if (nxt == C_END) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cmd_d   = nxt;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fail_go) begin
      err_d   = 1'b1;
      code_d  = fail_code;
      state_d = S_FAIL;
    end

    // Card selected only while a command/response exchange is in progress
    cs_n_d = !((state_d == S_ISSUE) || (state_d == S_WAIT_CMD) || (state_d == S_POLL) ||
               (state_d == S_EVAL) || (state_d == S_TAIL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd       <= C_CMD0;
      nxt       <= C_CMD0;
      cnt       <= '0;
      retry     <= '0;
      r1        <= '0;
      tail_b    <= '0;
      pend      <= 1'b0;
      seq_start <= 1'b0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_code  <= 3'd0;
      card_hc   <= 1'b0;
      cs_n      <= 1'b1;
      com_start <= 1'b0;
      com_cmd   <= 8'h00;
      com_arg   <= 24'h000000;
    end else begin
      state     <= state_d;
      cmd       <= cmd_d;
      nxt       <= nxt_d;
      cnt       <= cnt_d;
      retry     <= retry_d;
      r1        <= r1_d;
      tail_b    <= tail_d;
      pend      <= pend_d;
      seq_start <= seq_start_d;
      init_busy <= (state_d != S_IDLE);
      init_done <= done_d;
      init_err  <= err_d;
      err_code  <= code_d;
      card_hc   <= hc_d;
      cs_n      <= cs_n_d;
      com_start <= (state_d == S_ISSUE);
      {com_cmd, com_arg} <= cmd_enc(cmd_d);
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Bench for sd_init_sequencer: behavioural formatter, transceiver and SD card with a command scoreboard.
`timescale 1ns/1ps
module tb_sd_init_sequencer;

  logic        clk = 1'b0;
  logic        rst, init_start, init_busy, init_done, init_err, card_hc, cs_n;
  logic        com_start, com_rdy, cmdr_start, cmdr_rdy, spi_start, spi_rdy;
  logic [2:0]  err_code;
  logic [7:0]  com_cmd, cmdr_data, spi_data, spi_rx;
  logic [23:0] com_arg;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cmd_q[$];
  logic [7:0]  rx_q[$], cmd8_resp[$], acmd_resp[$], ocr_resp[$];
  bit          cmd0_silent = 1'b0, in_cmd = 1'b0, seen_cmd = 1'b0;
  int          dummy_cnt = 0, acmd41_cnt = 0;
  logic [7:0]  last_cmd = 8'hFF;
  bit          xv_busy = 1'b0, xv_from_cmd = 1'b0;
  int          xv_wait = 0, fm_k = 0;
  logic [7:0]  xv_val = 8'hFF;
  logic [31:0] fm_exp;
`ifdef SD_INIT_OCR_EN
  localparam bit OCR = 1'b1;
`else
  localparam bit OCR = 1'b0;
`endif

  always #5 clk = ~clk;

  sd_init_sequencer #(.DUMMY_BYTES(10), .RESP_POLL(8), .ACMD41_RETRIES(4)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done), .init_err(init_err), .err_code(err_code), .card_hc(card_hc),
    .cs_n(cs_n), .com_start(com_start), .com_cmd(com_cmd), .com_arg(com_arg),
    .com_rdy(com_rdy), .cmdr_start(cmdr_start), .cmdr_data(cmdr_data), .cmdr_rdy(cmdr_rdy),
    .spi_start(spi_start), .spi_data(spi_data), .spi_rdy(spi_rdy), .spi_rx(spi_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transceiver + card: 2-cycle byte latency, answers from rx_q only on sequencer bytes with cs_n low
  always @(negedge clk) begin
    #1;
    if (spi_rdy) begin spi_rdy = 1'b0; spi_rx = 8'h00; end
    if (xv_busy) begin
      xv_wait--;
      if (xv_wait == 0) begin
        xv_busy = 1'b0;
        spi_rdy = 1'b1;
        spi_rx  = xv_val;
        #2;
        if (xv_from_cmd) check("cmdr_rdy_mirror", 32'(cmdr_rdy), 32'(spi_rdy));
        else             check("cmdr_rdy_gated", 32'(cmdr_rdy), 32'd0);
      end
    end else if (spi_start) begin
      xv_from_cmd = in_cmd;
      xv_busy     = 1'b1;
      xv_wait     = 2;
      if (cs_n) begin
        xv_val = 8'hFF;
        if (!seen_cmd) dummy_cnt++;
      end else if (in_cmd || rx_q.size() == 0) xv_val = 8'hFF;
      else xv_val = rx_q.pop_front();
      if (!in_cmd) check("seq_spi_data", 32'(spi_data), 32'h0000_00FF);
    end
  end

  // Command formatter: scoreboard pop on com_start, six bytes, then com_rdy
  always begin
    @(negedge clk); #2;
    if (com_start) begin
      seen_cmd = 1'b1;
      in_cmd   = 1'b1;
      fm_exp   = (exp_cmd_q.size() != 0) ? exp_cmd_q.pop_front() : 32'hDEAD_BEEF;
      check("cmd_issued", {com_cmd, com_arg}, fm_exp);
      rx_q.delete();
      case (com_cmd[5:0])
        6'd0:  if (!cmd0_silent) begin rx_q.push_back(8'hFF); rx_q.push_back(8'h01); end
        6'd8:  rx_q = cmd8_resp;
        6'd55: rx_q.push_back(8'h01);
        6'd41: begin
          acmd41_cnt++;
          rx_q.push_back((acmd_resp.size() != 0) ? acmd_resp.pop_front() : 8'h01);
        end
        6'd58: begin
          rx_q.push_back(8'h00);
          foreach (ocr_resp[i]) rx_q.push_back(ocr_resp[i]);
        end
        default: ;
      endcase
      for (int b = 0; b < 6; b++) begin
        cmdr_data  = 8'(8'h40 + b);
        cmdr_start = 1'b1;
        @(negedge clk); #2;
        cmdr_start = 1'b0;
        fm_k = 0;
        while (!cmdr_rdy && fm_k < 64) begin @(negedge clk); #2; fm_k++; end
        if (!cmdr_rdy) check("cmdr_rdy_wait", 32'(cmdr_rdy), 32'd1);
      end
      com_rdy = 1'b1;
      @(negedge clk); #2;
      com_rdy  = 1'b0;
      in_cmd   = 1'b0;
      last_cmd = com_cmd;
    end
  end

  task automatic step();
    @(negedge clk); #4;
  endtask

  task automatic expect_cmds(input int pairs, input bit with58);
    exp_cmd_q.delete();
    exp_cmd_q.push_back(32'h00_000000);
    exp_cmd_q.push_back(32'h08_0001AA);
    for (int i = 0; i < pairs; i++) begin
      exp_cmd_q.push_back(32'h37_000000);
      exp_cmd_q.push_back(32'h69_000000);
    end
    if (with58) exp_cmd_q.push_back(32'h3A_000000);
  endtask

  task automatic run_init(input int budget);
    int k;
    seen_cmd   = 1'b0;
    dummy_cnt  = 0;
    acmd41_cnt = 0;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check("busy_after_start", 32'(init_busy), 32'd1);
    check("status_cleared", 32'({init_done, init_err, err_code, card_hc}), 32'd0);
    k = 0;
    while (init_busy && k < budget) begin step(); k++; end
    if (init_busy) check("busy_timeout", 32'(init_busy), 32'd0);
  endtask

  task automatic check_end(input string tag, input bit done, input bit err,
                           input logic [2:0] code, input bit hc);
    check({tag, ".done"}, 32'(init_done), 32'(done));
    check({tag, ".err"}, 32'(init_err), 32'(err));
    check({tag, ".code"}, 32'(err_code), 32'(code));
    check({tag, ".hc"}, 32'(card_hc), 32'(hc));
    check({tag, ".cs_n"}, 32'(cs_n), 32'd1);
    check({tag, ".cmds_left"}, 32'(exp_cmd_q.size()), 32'd0);
  endtask

  task automatic good_card(input logic [7:0] ocr0);
    cmd0_silent = 1'b0;
    cmd8_resp   = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    acmd_resp   = '{8'h01, 8'h01, 8'h00};
    ocr_resp    = '{ocr0, 8'hFF, 8'h80, 8'h00};
  endtask

  initial begin
    int k;
    rst = 1'b1; init_start = 1'b0; com_rdy = 1'b0; cmdr_start = 1'b0;
    cmdr_data = 8'h00; spi_rdy = 1'b0; spi_rx = 8'h00;
    repeat (3) step();
    check("rst.outputs", 32'({init_busy, init_done, init_err, err_code, card_hc, com_start,
                              cmdr_rdy, spi_start}), 32'd0);
    check("rst.cs_n", 32'(cs_n), 32'd1);
    check("rst.com", {com_cmd, com_arg}, 32'd0);
    rst = 1'b0;
    step();

    // Ready card, two ACMD41 idle replies before ready
    good_card(8'hC0);
    expect_cmds(3, OCR);
    run_init(4000);
    check_end("happy", 1'b1, 1'b0, 3'd0, OCR);
    check("happy.dummy_bytes", 32'(dummy_cnt), 32'd10);
    check("happy.acmd41_pairs", 32'(acmd41_cnt), 32'd3);

    // No response to CMD0
    cmd0_silent = 1'b1;
    exp_cmd_q.delete();
    exp_cmd_q.push_back(32'h00_000000);
    run_init(4000);
    check_end("cmd0_timeout", 1'b0, 1'b1, 3'd4, 1'b0);
    cmd0_silent = 1'b0;

    // CMD8 echo mismatch
    cmd8_resp = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h55};
    expect_cmds(0, 1'b0);
    run_init(4000);
    check_end("cmd8_echo", 1'b0, 1'b1, 3'd2, 1'b0);

    // CMD8 illegal command (v1 card)
    cmd8_resp = '{8'h05};
    expect_cmds(0, 1'b0);
    run_init(4000);
    check_end("cmd8_v1", 1'b0, 1'b1, 3'd5, 1'b0);

    // ACMD41 never leaves idle
    good_card(8'hC0);
    acmd_resp.delete();
    expect_cmds(4, 1'b0);
    run_init(6000);
    check_end("acmd41_timeout", 1'b0, 1'b1, 3'd3, 1'b0);
    check("acmd41_timeout.pairs", 32'(acmd41_cnt), 32'd4);

    // Reset while polling the CMD8 response
    cmd8_resp.delete();
    expect_cmds(0, 1'b0);
    last_cmd = 8'hFF; seen_cmd = 1'b0;
    init_start = 1'b1; step(); init_start = 1'b0;
    k = 0;
    while (last_cmd != 8'h08 && k < 2000) begin step(); k++; end
    check("rst_mid.reached_cmd8", 32'(last_cmd), 32'h08);
    step(); step();
    check("rst_mid.in_poll_cs_n", 32'(cs_n), 32'd0);
    rst = 1'b1;
    step();
    check("rst_mid.cs_n", 32'(cs_n), 32'd1);
    check("rst_mid.busy", 32'(init_busy), 32'd0);
    check("rst_mid.spi_start", 32'(spi_start), 32'd0);
    rst = 1'b0;
    repeat (10) step();
    check("rst_mid.cmds_left", 32'(exp_cmd_q.size()), 32'd0);

    // Restart after reset; OCR bit6 clear gives a standard-capacity card
    good_card(8'h80);
    expect_cmds(3, OCR);
    run_init(4000);
    check_end("restart", 1'b1, 1'b0, 3'd0, 1'b0);
    check("restart.dummy_bytes", 32'(dummy_cnt), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Brings an SPI-mode SD card from power-up to ready on request.
- Drives the card through the SPI command formatter (5-byte command plus CRC7, com_start/com_rdy handshake) and reads the response bytes directly.
- Arbitrates the single byte transceiver between the formatter and its own dummy-byte and response-poll traffic.
- Sits between the system controller and the SPI byte engine.

Parameters:
- DUMMY_BYTES, 10, number of 0xFF bytes sent with cs_n=1 at power-up (80 SCLKs).
- RESP_POLL, 8, maximum 0xFF bytes polled for an R1 response before declaring a timeout.
- ACMD41_RETRIES, 1000, maximum CMD55/ACMD41 pairs before giving up; 16-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- init_start  in  1  one-cycle pulse that starts the sequence
- init_busy  out  1  high while the sequence is running
- init_done  out  1  level; card ready
- init_err  out  1  level; sequence failed
- err_code  out  3  failure code: 0 none, 1 CMD0 R1!=0x01, 2 CMD8 echo mismatch, 3 ACMD41 timeout, 4 R1 poll timeout, 5 v1 card (CMD8 illegal)
- card_hc  out  1  high-capacity card flag
- cs_n  out  1  card chip select
- com_start  out  1  command request to the formatter
- com_cmd  out  8  {arg[31:30], index[5:0]}
- com_arg  out  24  command argument bits [23:0]
- com_rdy  in  1  formatter has finished the command
- cmdr_start  in  1  byte start from the formatter
- cmdr_data  in  8  byte data from the formatter
- cmdr_rdy  out  1  byte done, returned to the formatter
- spi_start  out  1  byte start to the transceiver
- spi_data  out  8  byte to the transceiver
- spi_rdy  in  1  transceiver byte done (1-cycle pulse)
- spi_rx  in  8  byte received by the transceiver, valid with spi_rdy

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: all outputs 0 except cs_n=1; the byte arbiter selects the sequencer. A reset mid-sequence forces IDLE immediately and does not wait for an in-flight byte.
- Byte arbiter: sel=CMDR from the com_start cycle until com_rdy, otherwise sel=SEQ.
  - sel=CMDR: spi_start/spi_data = cmdr_start/cmdr_data, cmdr_rdy=spi_rdy.
  - sel=SEQ: cmdr_rdy=0, spi_data=0xFF; the sequencer pulses spi_start for 1 cycle and waits for spi_rdy before issuing the next byte.
- Command encodings (com_cmd/com_arg):
  - CMD0: 0x00 / 0x000000
  - CMD8: 0x08 / 0x0001AA
  - CMD55: 0x37 / 0x000000
  - ACMD41: 0x69 / 0x000000 (arg[30]=HCS)
  - CMD58: 0x3A / 0x000000
- com_start is a 1-cycle pulse issued in state ISSUE; the sequencer then waits in WAIT_CMD for com_rdy.
- FSM states and transitions:
  - IDLE: on init_start, clear done/err/err_code/card_hc, go to PWRUP. init_start is ignored in every other state.
  - PWRUP: cs_n=1; send DUMMY_BYTES bytes; go to ISSUE(CMD0).
  - ISSUE → WAIT_CMD → POLL. cs_n=0 from the ISSUE cycle.
  - POLL: send 0xFF, capture spi_rx. If bit7=0 the byte is R1, go to EVAL. After RESP_POLL bytes with no R1 → FAIL(4).
  - EVAL, CMD0: R1 must be 0x01, else FAIL(1).
  - EVAL, CMD8:
    - R1 bit2=1 → FAIL(5).
    - R1=0x01 → TAIL reads 4 bytes; the last two must be 0x01 and 0xAA, else FAIL(2).
    - Any other R1 → FAIL(1).
  - EVAL, CMD55: no check; go to ISSUE(ACMD41).
  - EVAL, ACMD41:
    - R1=0x00 → next stage.
    - R1=0x01 → increment retry counter and ISSUE(CMD55).
    - Counter reaching ACMD41_RETRIES → FAIL(3).
    - Any other R1 → FAIL(1).
  - GAP: after every response (and its TAIL), cs_n=1 and one 0xFF byte is sent before the next ISSUE or the final state.
  - DONE: init_done=1, back to IDLE. FAIL(c): init_err=1, err_code=c, cs_n=1, back to IDLE.
- Status outputs: done/err/err_code hold until the next init_start or rst. init_busy=1 in every state except IDLE.
- Retry counter: saturates and never wraps.

Optional Feature:
- Macro SD_INIT_OCR_EN.
- Defined: after ACMD41 returns 0x00, issue CMD58. R1 must be 0x00, else FAIL(1). TAIL reads 4 OCR bytes and card_hc = bit6 of the first OCR byte. Then DONE.
- Undefined: no CMD58 is sent, card_hc is held at 0, and DONE follows the ACMD41 GAP directly.

Test Plan:
- Card model returns 0x01, CMD8 tail 00 00 01 AA, then ACMD41 0x01 twice and 0x00 → exactly 10 dummy bytes with cs_n=1; 3 CMD55/ACMD41 pairs; init_done=1; err_code=0.
- CMD0 response 0xFF for 8 polls → init_err=1, err_code=4, cs_n=1, no CMD8 issued.
- CMD8 tail 00 00 01 55 → err_code=2. CMD8 R1=0x05 → err_code=5.
- ACMD41 always returns 0x01, with ACMD41_RETRIES=4 → exactly 4 pairs, then err_code=3.
- rst asserted in POLL of the CMD8 step → next cycle cs_n=1, init_busy=0, spi_start=0; a later init_start restarts from PWRUP.
- With SD_INIT_OCR_EN defined, OCR C0 FF 80 00 → card_hc=1; OCR 80 FF 80 00 → card_hc=0. During commands, cmdr_rdy mirrors spi_rdy cycle-exactly.
